d_ff: RTL and testbench

D_FF -- requirements
Module: d_ff

---
 rtl/d_ff.sv | 28 ++
 tb/tb_d_ff.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// Single D flip-flop with synchronous active-high reset to RESET_VAL.
// q is taken straight from the register, so there is no path from d or reset to q.
module d_ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb q_d = d;

    // Reset is looked at only on the clock edge, and it takes priority over d.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a vector table plus hand-written sequences for the
// between-edge cases, and a 64-wide bank of instances acting as one register.
`timescale 1ns/1ps
module tb_d_ff;

    typedef struct packed {
        logic reset;
        logic d;
        logic exp_q;
        logic exp_q1;
    } vec_t;

    localparam int NVEC = 19;

    logic        clk;
    logic        reset;
    logic        d;
    logic        q;
    logic        q1;
    logic        reset_w;
    logic [63:0] d_w;
    logic [63:0] q_w;

    int n_vec;
    int n_err;

    vec_t vecs [NVEC];

    d_ff dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    d_ff #(.RESET_VAL(1'b1)) dut_set (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q1)
    );

    for (genvar i = 0; i < 64; i++) begin : g_bank
        d_ff u_bit (
            .clk   (clk),
            .reset (reset_w),
            .d     (d_w[i]),
            .q     (q_w[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change one time unit after a rising edge; outputs are read at the same point.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        d       = 1'b1;
        reset_w = 1'b1;
        d_w     = 64'd0;

        vecs = '{
            '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1}
        };

        #2;
        for (int i = 0; i < NVEC; i++) begin
            reset = vecs[i].reset;
            d     = vecs[i].d;
            edge_step();
            check($sformatf("vec%0d q", i), {63'd0, q}, {63'd0, vecs[i].exp_q});
            check($sformatf("vec%0d q_rv1", i), {63'd0, q1}, {63'd0, vecs[i].exp_q1});
        end

        // q=1, d=1 here. Wiggle d between edges: q must hold until the next edge.
        #1 d = 1'b0;
        #2 check("mid_toggle_a", {63'd0, q}, 64'd1);
        d = 1'b1;
        #2 d = 1'b0;
        #1 check("mid_toggle_b", {63'd0, q}, 64'd1);
        edge_step();
        check("mid_toggle_edge", {63'd0, q}, 64'd0);

        // Reset pulse that never reaches an edge has no effect.
        d = 1'b1;
        edge_step();
        check("pre_pulse", {63'd0, q}, 64'd1);
        #1 reset = 1'b1;
        #3 reset = 1'b0;
        #1 check("pulse_between", {63'd0, q}, 64'd1);
        edge_step();
        check("pulse_after_edge", {63'd0, q}, 64'd1);
        check("pulse_after_edge_rv1", {63'd0, q1}, 64'd1);

        // Reset with d=1 wins, then the first edge after release loads d.
        reset = 1'b1;
        d     = 1'b1;
        edge_step();
        check("reset_wins", {63'd0, q}, 64'd0);
        reset = 1'b0;
        edge_step();
        check("release_load", {63'd0, q}, 64'd1);

        // 64 instances behave as one register with independent bits.
        reset_w = 1'b1;
        d_w     = 64'd34324;
        edge_step();
        check("bank_reset_a", q_w, 64'd0);
        edge_step();
        check("bank_reset_b", q_w, 64'd0);
        reset_w = 1'b0;
        #2 check("bank_before_edge", q_w, 64'd0);
        edge_step();
        check("bank_load", q_w, 64'd34324);
        d_w = 64'd6823;
        #3 check("bank_hold", q_w, 64'd34324);
        edge_step();
        check("bank_update", q_w, 64'd6823);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
